// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the iterative divider.
//   div_op_e    : operation encoding, matches funct3[1:0] of the RV32M divide group
//   div_state_e : control FSM states
//   op_is_signed / op_is_rem : decode helpers for div_op_e
package iterative_divider_pkg;

    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_e;

    function automatic logic op_is_signed(div_op_e op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic op_is_rem(div_op_e op);
        return (op == OpRem) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/iterative_divider_div_step.sv
// One combinational restoring-division step.
//   rem_i     [Size:0]   partial remainder from the previous step
//   dvd_msb_i            next dividend bit shifted into the remainder
//   divisor_i [Size-1:0] divisor magnitude
//   rem_o     [Size:0]   partial remainder after the conditional subtract
//   q_bit_o              quotient bit produced by this step
module iterative_divider_div_step #(
    parameter int unsigned Size = 32
) (
    input  logic [Size:0]   rem_i,
    input  logic            dvd_msb_i,
    input  logic [Size-1:0] divisor_i,
    output logic [Size:0]   rem_o,
    output logic            q_bit_o
);

    logic [Size:0]   shifted;
    logic [Size+1:0] diff;

    assign shifted = {rem_i[Size-1:0], dvd_msb_i};

    // Subtract as shifted + ~divisor + 1; the carry-out is set exactly when
    // shifted >= divisor (no borrow).
    assign diff = {1'b0, shifted} + {1'b0, ~{1'b0, divisor_i}} + {{(Size+1){1'b0}}, 1'b1};

    // A set top bit on the incoming remainder would mean the shifted value
    // exceeds any divisor; it never happens with a restoring sequence but keeps
    // the step correct for any input.
    assign q_bit_o = diff[Size+1] | rem_i[Size];
    assign rem_o   = q_bit_o ? diff[Size:0] : shifted;

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring shift-subtract, one quotient bit per cycle, fixed latency Size+2.
//   clk_i     clock, rising edge
//   reset_i   synchronous active-high reset
//   start_i   request, sampled only in idle/done
//   op_i      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a_i, b_i  dividend / divisor, sampled with start_i
//   flush_i   synchronous abort
//   busy_o    operation in progress (stall request)
//   valid_o   one-cycle pulse, result_o is valid
//   result_o  quotient or remainder, held until overwritten by the next op
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int unsigned Size = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [Size-1:0] a_i,
    input  logic [Size-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [Size-1:0] result_o
);

    localparam int unsigned    CntW    = (Size > 1) ? $clog2(Size) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Size - 1);
    localparam logic [Size-1:0] MinNeg  = {1'b1, {(Size-1){1'b0}}};

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    logic [Size-1:0] dvd_q, dvd_d;      // dividend shifting out, quotient shifting in
    logic [Size-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic [Size-1:0] a_q, a_d;          // raw dividend for the divide-by-zero remainder
    logic [Size:0]   rem_q, rem_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            quot_neg_q, quot_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic [Size-1:0] result_q, result_d;

    // Operand conditioning for a new request.
    div_op_e         in_op;
    logic            in_signed;
    logic [Size-1:0] abs_a, abs_b;

    assign in_op     = div_op_e'(op_i);
    assign in_signed = op_is_signed(in_op);
    assign abs_a     = (in_signed && a_i[Size-1]) ? -a_i : a_i;
    assign abs_b     = (in_signed && b_i[Size-1]) ? -b_i : b_i;

    logic [Size:0] step_rem;
    logic          step_q;

    iterative_divider_div_step #(
        .Size (Size)
    ) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[Size-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    // Sign correction and special cases, applied in the fix cycle.
    logic [Size-1:0] quot_fix, rem_fix, fix_result;

    assign quot_fix = quot_neg_q ? -dvd_q : dvd_q;
    assign rem_fix  = rem_neg_q ? -rem_q[Size-1:0] : rem_q[Size-1:0];

    always_comb begin
        fix_result = quot_fix;
        if (op_is_rem(op_q)) begin
            if (div0_q) begin
                fix_result = a_q;
            end else if (ovf_q) begin
                fix_result = '0;
            end else begin
                fix_result = rem_fix;
            end
        end else begin
            if (div0_q) begin
                fix_result = '1;
            end else if (ovf_q) begin
                fix_result = MinNeg;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        a_d        = a_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        div0_d     = div0_q;
        ovf_d      = ovf_q;
        result_d   = result_q;

        if (flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (start_i) begin
                        state_d    = StRun;
                        op_d       = in_op;
                        dvd_d      = abs_a;
                        dvs_d      = abs_b;
                        a_d        = a_i;
                        rem_d      = '0;
                        cnt_d      = CntLast;
                        quot_neg_d = in_signed & (a_i[Size-1] ^ b_i[Size-1]);
                        rem_neg_d  = in_signed & a_i[Size-1];
                        div0_d     = (b_i == '0);
                        ovf_d      = in_signed & (a_i == MinNeg) & (b_i == '1);
                    end
                end
                StRun: begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[Size-2:0], step_q};
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    result_d = fix_result;
                    state_d  = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            op_q       <= OpDiv;
            dvd_q      <= '0;
            dvs_q      <= '0;
            a_q        <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            a_q        <= a_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            div0_q     <= div0_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
        end
    end

    assign busy_o   = (state_q == StRun) || (state_q == StFix);
    assign valid_o  = (state_q == StDone);
    assign result_o = result_q;

endmodule
